// File: rtl/capture_pkg.sv
// Opcodes of the SUMP-style command set and the acquisition state encoding.
package capture_pkg;

   localparam logic [7:0] OP_RESET   = 8'h00;
   localparam logic [7:0] OP_ARM     = 8'h01;
   localparam logic [7:0] OP_ID      = 8'h02;
   localparam logic [7:0] OP_META    = 8'h04;
   localparam logic [7:0] OP_DIVIDER = 8'h80;
   localparam logic [7:0] OP_COUNTS  = 8'h81;
   localparam logic [7:0] OP_RISE    = 8'hC0;
   localparam logic [7:0] OP_FALL    = 8'hC1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_META_WAIT,
      ST_ARMED,
      ST_CAPTURE,
      ST_DUMP
   } state_t;

endpackage

// File: rtl/capture_controller_counter.sv
// Post-trigger sample down-counter: load, decrement on enable (saturating at zero), zero flag.
// Registered count, one-cycle update; no backpressure.
module post_trigger_counter #(
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clock,
   input  logic                   ext_reset,
   input  logic                   load,
   input  logic [COUNT_WIDTH-1:0] load_value,
   input  logic                   dec,
   output logic [COUNT_WIDTH-1:0] count,
   output logic                   zero
);

   always_ff @(posedge clock) begin
      if (ext_reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (dec && (count != '0)) begin
         count <= count - COUNT_WIDTH'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/capture_controller.sv
// Acquisition sequencer and capture config registers; CAPTURE_ABORT_EN lets opcode 0x00 abort ARMED/CAPTURE/DUMP.
// All outputs registered, one-cycle response; no backpressure, meta_busy/dump_busy only hold META_WAIT/DUMP.
module capture_controller
   import capture_pkg::*;
#(
   parameter int SAMPLE_WIDTH = 8,
   parameter int DIV_WIDTH    = 24,
   parameter int COUNT_WIDTH  = 16
) (
   input  logic                    clock,
   input  logic                    ext_reset,
   input  logic [7:0]              opcode,
   input  logic [31:0]             command,
   input  logic                    cmd_recv_rx,
   input  logic                    run,
   input  logic                    sample_en,
   input  logic                    meta_busy,
   input  logic                    dump_busy,
   output logic                    reset,
   output logic [DIV_WIDTH-1:0]    divider,
   output logic [COUNT_WIDTH-1:0]  read_count,
   output logic [COUNT_WIDTH-1:0]  delay_count,
   output logic [SAMPLE_WIDTH-1:0] rise_pattern,
   output logic [SAMPLE_WIDTH-1:0] fall_pattern,
   output logic                    arm,
   output logic                    data_meta_mux,
   output logic                    send_id,
   output logic                    begin_meta_transmit,
   output logic                    begin_dump,
   output logic                    capture_active
);

   state_t                 state;
   logic                   cnt_load;
   logic                   cnt_dec;
   logic                   cnt_zero;
   logic [COUNT_WIDTH-1:0] cnt_value;
   logic                   capture_done;
   logic                   abort;

   assign cnt_load = (state == ST_ARMED) && run;
   assign cnt_dec  = (state == ST_CAPTURE) && sample_en;

   // Dump on the sample that takes the count to zero; a zero delay dumps on the first sample.
   assign capture_done = cnt_dec && (cnt_zero || (cnt_value == COUNT_WIDTH'(1)));

`ifdef CAPTURE_ABORT_EN
   assign abort = cmd_recv_rx && (opcode == OP_RESET) &&
                  (state inside {ST_ARMED, ST_CAPTURE, ST_DUMP});
`else
   assign abort = 1'b0;
`endif

   post_trigger_counter #(
      .COUNT_WIDTH (COUNT_WIDTH)
   ) u_counter (
      .clock      (clock),
      .ext_reset  (ext_reset),
      .load       (cnt_load),
      .load_value (delay_count),
      .dec        (cnt_dec),
      .count      (cnt_value),
      .zero       (cnt_zero)
   );

   always_ff @(posedge clock) begin
      if (ext_reset) begin
         state               <= ST_IDLE;
         reset               <= 1'b0;
         divider             <= '0;
         read_count          <= '0;
         delay_count         <= '0;
         rise_pattern        <= '0;
         fall_pattern        <= '0;
         arm                 <= 1'b0;
         data_meta_mux       <= 1'b0;
         send_id             <= 1'b0;
         begin_meta_transmit <= 1'b0;
         begin_dump          <= 1'b0;
         capture_active      <= 1'b0;
      end else begin
         reset               <= 1'b0;
         send_id             <= 1'b0;
         begin_meta_transmit <= 1'b0;
         begin_dump          <= 1'b0;

         if (abort) begin
            reset          <= 1'b1;
            arm            <= 1'b0;
            data_meta_mux  <= 1'b0;
            capture_active <= 1'b0;
            state          <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (cmd_recv_rx) begin
                     case (opcode)
                        OP_RESET: begin
                           reset          <= 1'b1;
                           arm            <= 1'b0;
                           data_meta_mux  <= 1'b0;
                           capture_active <= 1'b0;
                        end
                        OP_ARM: begin
                           arm            <= 1'b1;
                           capture_active <= 1'b1;
                           state          <= ST_ARMED;
                        end
                        OP_ID, OP_META: begin
                           begin_meta_transmit <= 1'b1;
                           send_id             <= (opcode == OP_ID);
                           data_meta_mux       <= 1'b0;
                           state               <= ST_META_WAIT;
                        end
                        OP_DIVIDER: divider      <= command[DIV_WIDTH-1:0];
                        OP_COUNTS: begin
                           read_count  <= command[COUNT_WIDTH-1:0];
                           delay_count <= command[16+COUNT_WIDTH-1:16];
                        end
                        OP_RISE:    rise_pattern <= command[SAMPLE_WIDTH-1:0];
                        OP_FALL:    fall_pattern <= command[SAMPLE_WIDTH-1:0];
                        default: ;
                     endcase
                  end
               end
               // The start-pulse cycle is treated as busy so the peer has time to raise its flag.
               ST_META_WAIT: begin
                  if (!meta_busy && !begin_meta_transmit) state <= ST_IDLE;
               end
               ST_ARMED: begin
                  if (run) state <= ST_CAPTURE;
               end
               ST_CAPTURE: begin
                  if (capture_done) begin
                     arm           <= 1'b0;
                     data_meta_mux <= 1'b1;
                     begin_dump    <= 1'b1;
                     state         <= ST_DUMP;
                  end
               end
               ST_DUMP: begin
                  if (!dump_busy && !begin_dump) begin
                     data_meta_mux  <= 1'b0;
                     capture_active <= 1'b0;
                     state          <= ST_IDLE;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_capture_controller.sv
// Self-checking bench for capture_controller: directed scenarios plus randomized captures against a behavioural model.
module tb_capture_controller;

   localparam int SW = 8;
   localparam int DW = 24;
   localparam int CW = 16;
`ifdef CAPTURE_ABORT_EN
   localparam bit ABORT = 1'b1;
`else
   localparam bit ABORT = 1'b0;
`endif

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic          ext_reset, cmd_recv_rx, run, sample_en, meta_busy, dump_busy;
   logic [7:0]    opcode;
   logic [31:0]   command;
   logic          reset, arm, data_meta_mux, send_id, begin_meta_transmit, begin_dump, capture_active;
   logic [DW-1:0] divider;
   logic [CW-1:0] read_count, delay_count;
   logic [SW-1:0] rise_pattern, fall_pattern;

   int checks = 0;
   int errors = 0;

   logic [7:0] ops [7] = '{8'hC0, 8'hC1, 8'h80, 8'h81, 8'h01, 8'h02, 8'h04};

   capture_controller #(
      .SAMPLE_WIDTH (SW),
      .DIV_WIDTH    (DW),
      .COUNT_WIDTH  (CW)
   ) dut (
      .clock               (clock),
      .ext_reset           (ext_reset),
      .opcode              (opcode),
      .command             (command),
      .cmd_recv_rx         (cmd_recv_rx),
      .run                 (run),
      .sample_en           (sample_en),
      .meta_busy           (meta_busy),
      .dump_busy           (dump_busy),
      .reset               (reset),
      .divider             (divider),
      .read_count          (read_count),
      .delay_count         (delay_count),
      .rise_pattern        (rise_pattern),
      .fall_pattern        (fall_pattern),
      .arm                 (arm),
      .data_meta_mux       (data_meta_mux),
      .send_id             (send_id),
      .begin_meta_transmit (begin_meta_transmit),
      .begin_dump          (begin_dump),
      .capture_active      (capture_active)
   );

   // Reference model: tracks the acquisition phase by name and counts samples seen after the trigger.
   string         m_mode = "idle";
   logic          m_reset = 0, m_arm = 0, m_dmm = 0, m_sid = 0, m_bmt = 0, m_bd = 0, m_act = 0;
   logic [DW-1:0] m_div = 0;
   logic [CW-1:0] m_read = 0, m_delay = 0;
   logic [SW-1:0] m_rise = 0, m_fall = 0;
   int            m_needed = 0, m_seen = 0;

   always @(posedge clock) begin : ref_model
      string         nm;
      logic          n_reset, n_arm, n_dmm, n_sid, n_bmt, n_bd;
      logic [DW-1:0] n_div;
      logic [CW-1:0] n_read, n_delay;
      logic [SW-1:0] n_rise, n_fall;
      int            n_needed, n_seen;
      nm = m_mode; n_arm = m_arm; n_dmm = m_dmm; n_div = m_div; n_read = m_read; n_delay = m_delay;
      n_rise = m_rise; n_fall = m_fall; n_needed = m_needed; n_seen = m_seen;
      n_reset = 0; n_sid = 0; n_bmt = 0; n_bd = 0;
      if (ext_reset) begin
         nm = "idle"; n_arm = 0; n_dmm = 0; n_div = 0; n_read = 0; n_delay = 0; n_rise = 0; n_fall = 0;
      end else if (ABORT && cmd_recv_rx && opcode == 8'h00 && nm != "idle" && nm != "meta") begin
         n_reset = 1; n_arm = 0; n_dmm = 0; nm = "idle";
      end else if (nm == "idle") begin
         if (cmd_recv_rx) begin
            if (opcode == 8'h00) n_reset = 1;
            else if (opcode == 8'h01) begin n_arm = 1; nm = "armed"; end
            else if (opcode == 8'h02 || opcode == 8'h04) begin
               n_bmt = 1; n_sid = (opcode == 8'h02); n_dmm = 0; nm = "meta";
            end
            else if (opcode == 8'h80) n_div = DW'(command % 32'h0100_0000);
            else if (opcode == 8'h81) begin
               n_read = CW'(command % 32'h1_0000); n_delay = CW'(command / 32'h1_0000);
            end
            else if (opcode == 8'hC0) n_rise = SW'(command % 32'h100);
            else if (opcode == 8'hC1) n_fall = SW'(command % 32'h100);
         end
      end else if (nm == "meta") begin
         if (!meta_busy && !m_bmt) nm = "idle";
      end else if (nm == "armed") begin
         if (run) begin
            n_needed = (m_delay == 0) ? 1 : int'(m_delay);
            n_seen = 0;
            nm = "capture";
         end
      end else if (nm == "capture") begin
         if (sample_en) begin
            n_seen = m_seen + 1;
            if (n_seen >= m_needed) begin n_arm = 0; n_dmm = 1; n_bd = 1; nm = "dump"; end
         end
      end else if (nm == "dump") begin
         if (!dump_busy && !m_bd) begin n_dmm = 0; nm = "idle"; end
      end
      m_mode <= nm; m_reset <= n_reset; m_arm <= n_arm; m_dmm <= n_dmm; m_sid <= n_sid; m_bmt <= n_bmt;
      m_bd <= n_bd; m_div <= n_div; m_read <= n_read; m_delay <= n_delay; m_rise <= n_rise; m_fall <= n_fall;
      m_needed <= n_needed; m_seen <= n_seen;
      m_act <= (nm == "armed" || nm == "capture" || nm == "dump");
   end

   function automatic logic [78:0] obs_vec();
      return {reset, arm, data_meta_mux, send_id, begin_meta_transmit, begin_dump, capture_active,
              divider, read_count, delay_count, rise_pattern, fall_pattern};
   endfunction

   function automatic logic [78:0] exp_vec();
      return {m_reset, m_arm, m_dmm, m_sid, m_bmt, m_bd, m_act, m_div, m_read, m_delay, m_rise, m_fall};
   endfunction

   task automatic send_cmd(input logic [7:0] op, input logic [31:0] arg);
      opcode = op; command = arg; cmd_recv_rx = 1'b1;
      @(negedge clock);
      cmd_recv_rx = 1'b0; opcode = 8'($urandom); command = $urandom;
   endtask

   task automatic test_reset();
      ext_reset = 1'b1;
      repeat (2) @(negedge clock);
      checks++;
      if (obs_vec() !== '0) begin errors++; $display("FAIL reset_state: got %h expected 0", obs_vec()); end
      ext_reset = 1'b0;
      @(negedge clock);
      checks++;
      if (obs_vec() !== '0 || obs_vec() !== exp_vec())
         begin errors++; $display("FAIL reset_release: got %h expected 0 (model %h)", obs_vec(), exp_vec()); end
   endtask

   task automatic test_configure();
      logic [31:0] r;
      logic [7:0]  op;
      send_cmd(8'h80, 32'h0000_1234);
      checks++;
      if (divider !== 24'h001234) begin errors++; $display("FAIL cfg_divider: got %h expected 001234", divider); end
      send_cmd(8'h81, 32'h0003_0010);
      checks++;
      if ({delay_count, read_count} !== {16'd3, 16'h0010})
         begin errors++; $display("FAIL cfg_counts: got delay %h read %h expected 3 / 10", delay_count, read_count); end
      r = $urandom;
      send_cmd(8'hC0, r);
      checks++;
      if (rise_pattern !== r[7:0]) begin errors++; $display("FAIL cfg_rise: got %h expected %h", rise_pattern, r[7:0]); end
      r = $urandom;
      send_cmd(8'hC1, r);
      checks++;
      if (fall_pattern !== r[7:0]) begin errors++; $display("FAIL cfg_fall: got %h expected %h", fall_pattern, r[7:0]); end
      for (int i = 0; i < 4; i++) begin
         do op = 8'($urandom); while (op inside {8'h00, 8'h01, 8'h02, 8'h04, 8'h80, 8'h81, 8'hC0, 8'hC1});
         send_cmd(op, $urandom);
         checks++;
         if (obs_vec() !== exp_vec() || divider !== 24'h001234 || capture_active !== 1'b0)
            begin errors++; $display("FAIL cfg_unknown op=%h: got %h expected %h", op, obs_vec(), exp_vec()); end
      end
      send_cmd(8'h00, $urandom);
      checks++;
      if ({reset, divider, delay_count} !== {1'b1, 24'h001234, 16'd3})
         begin errors++; $display("FAIL soft_reset_idle: got reset %b div %h delay %h", reset, divider, delay_count); end
      @(negedge clock);
      checks++;
      if (reset !== 1'b0) begin errors++; $display("FAIL soft_reset_width: got %b expected 0", reset); end
   endtask

   task automatic test_id_query();
      meta_busy = 1'b1;
      send_cmd(8'h02, $urandom);
      checks++;
      if ({begin_meta_transmit, send_id, data_meta_mux, capture_active} !== 4'b1100)
         begin errors++; $display("FAIL id_start: got %b expected 1100", {begin_meta_transmit, send_id, data_meta_mux, capture_active}); end
      @(negedge clock);
      checks++;
      if ({begin_meta_transmit, send_id} !== 2'b00)
         begin errors++; $display("FAIL id_pulse_width: got %b expected 00", {begin_meta_transmit, send_id}); end
      send_cmd(8'h80, 32'h00AB_CDEF);
      checks++;
      if (divider !== 24'h001234) begin errors++; $display("FAIL id_busy_drop: got %h expected 001234", divider); end
      repeat (17) @(negedge clock);
      meta_busy = 1'b0;
      send_cmd(8'h80, 32'h0011_1111);
      checks++;
      if (divider !== 24'h001234) begin errors++; $display("FAIL id_exit_edge_drop: got %h expected 001234", divider); end
      send_cmd(8'h80, 32'h0022_2222);
      checks++;
      if (divider !== 24'h222222) begin errors++; $display("FAIL id_back_to_idle: got %h expected 222222", divider); end
      send_cmd(8'h04, $urandom);
      checks++;
      if ({begin_meta_transmit, send_id, data_meta_mux} !== 3'b100)
         begin errors++; $display("FAIL meta_start: got %b expected 100", {begin_meta_transmit, send_id, data_meta_mux}); end
      send_cmd(8'h80, 32'h0033_3333);
      checks++;
      if (divider !== 24'h222222) begin errors++; $display("FAIL meta_pulse_is_busy: got %h expected 222222", divider); end
      send_cmd(8'h80, 32'h0044_4444);
      checks++;
      if (divider !== 24'h222222) begin errors++; $display("FAIL meta_exit_edge_drop: got %h expected 222222", divider); end
      send_cmd(8'h80, 32'h0000_1234);
      checks++;
      if (divider !== 24'h001234) begin errors++; $display("FAIL meta_back_to_idle: got %h expected 001234", divider); end
   endtask

   task automatic test_capture();
      send_cmd(8'h81, 32'h0003_0010);
      send_cmd(8'hC0, 32'h0000_005A);
      send_cmd(8'h01, $urandom);
      checks++;
      if ({arm, capture_active, data_meta_mux} !== 3'b110)
         begin errors++; $display("FAIL arm_start: got %b expected 110", {arm, capture_active, data_meta_mux}); end
      send_cmd(8'hC0, 32'h0000_00A5);
      checks++;
      if (rise_pattern !== 8'h5A) begin errors++; $display("FAIL armed_drop: got %h expected 5a", rise_pattern); end
      repeat (3) @(negedge clock);
      run = 1'b1; sample_en = 1'b1;
      @(negedge clock);
      sample_en = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         repeat ($urandom_range(0, 3)) @(negedge clock);
         sample_en = 1'b1;
         @(negedge clock);
         sample_en = 1'b0;
         checks++;
         if (k < 3 && {begin_dump, arm, data_meta_mux} !== 3'b010)
            begin errors++; $display("FAIL capture_early sample %0d: got %b expected 010", k, {begin_dump, arm, data_meta_mux}); end
         else if (k == 3 && {begin_dump, arm, data_meta_mux} !== 3'b101)
            begin errors++; $display("FAIL capture_dump: got %b expected 101", {begin_dump, arm, data_meta_mux}); end
      end
      dump_busy = 1'b1;
      @(negedge clock);
      checks++;
      if ({begin_dump, data_meta_mux, capture_active} !== 3'b011)
         begin errors++; $display("FAIL dump_pulse_width: got %b expected 011", {begin_dump, data_meta_mux, capture_active}); end
      repeat (9) @(negedge clock);
      checks++;
      if ({data_meta_mux, capture_active} !== 2'b11)
         begin errors++; $display("FAIL dump_hold: got %b expected 11", {data_meta_mux, capture_active}); end
      dump_busy = 1'b0;
      @(negedge clock);
      run = 1'b0;
      checks++;
      if ({data_meta_mux, capture_active, arm} !== 3'b000)
         begin errors++; $display("FAIL dump_done: got %b expected 000", {data_meta_mux, capture_active, arm}); end
      send_cmd(8'hC1, 32'h0000_003C);
      checks++;
      if (fall_pattern !== 8'h3C) begin errors++; $display("FAIL dump_idle_cmd: got %h expected 3c", fall_pattern); end
   endtask

   task automatic test_random_capture();
      for (int it = 0; it < 10; it++) begin
         logic [15:0] d;
         bit          done;
         d = 16'($urandom_range(0, 5));
         done = 1'b0;
         send_cmd(8'h81, {d, 16'($urandom)});
         send_cmd(8'h01, $urandom);
         repeat ($urandom_range(0, 4)) @(negedge clock);
         run = 1'b1;
         for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            sample_en = ($urandom_range(0, 2) == 0);
            dump_busy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) begin
               opcode = ops[$urandom_range(0, 6)]; command = $urandom; cmd_recv_rx = 1'b1;
            end else begin
               cmd_recv_rx = 1'b0;
            end
            @(negedge clock);
            checks++;
            if (obs_vec() !== exp_vec())
               begin errors++; $display("FAIL random_capture it=%0d cyc=%0d: got %h expected %h", it, cyc, obs_vec(), exp_vec()); end
            if (!m_arm) run = 1'b0;
            if (m_mode == "idle") done = 1'b1;
         end
         sample_en = 1'b0; dump_busy = 1'b0; cmd_recv_rx = 1'b0; run = 1'b0;
         checks++;
         if (!done) begin errors++; $display("FAIL random_timeout it=%0d: got no return to idle, expected one", it); end
      end
   endtask

   task automatic test_abort();
      send_cmd(8'h81, 32'h0004_0008);
      send_cmd(8'h01, $urandom);
      run = 1'b1;
      @(negedge clock);
      sample_en = 1'b1;
      @(negedge clock);
      sample_en = 1'b0;
      send_cmd(8'h00, $urandom);
      checks++;
      if (ABORT && {reset, arm, data_meta_mux, capture_active} !== 4'b1000)
         begin errors++; $display("FAIL abort_taken: got %b expected 1000", {reset, arm, data_meta_mux, capture_active}); end
      else if (!ABORT && {reset, arm, data_meta_mux, capture_active} !== 4'b0101)
         begin errors++; $display("FAIL abort_dropped: got %b expected 0101", {reset, arm, data_meta_mux, capture_active}); end
      run = 1'b0;
      send_cmd(8'hC0, 32'h0000_0077);
      checks++;
      if (rise_pattern !== (ABORT ? 8'h77 : 8'h5A) || obs_vec() !== exp_vec())
         begin errors++; $display("FAIL abort_followup: got rise %h vec %h expected vec %h", rise_pattern, obs_vec(), exp_vec()); end
      ext_reset = 1'b1;
      @(negedge clock);
      ext_reset = 1'b0;
   endtask

   task automatic test_reset_mid_dump();
      send_cmd(8'h80, {8'h00, 24'($urandom) | 24'h1});
      send_cmd(8'hC0, 32'h0000_00FF);
      send_cmd(8'hC1, 32'h0000_0081);
      send_cmd(8'h81, 32'h0000_0005);
      send_cmd(8'h01, $urandom);
      run = 1'b1;
      @(negedge clock);
      sample_en = 1'b1;
      @(negedge clock);
      sample_en = 1'b0;
      checks++;
      if ({begin_dump, data_meta_mux} !== 2'b11)
         begin errors++; $display("FAIL zero_delay_dump: got %b expected 11", {begin_dump, data_meta_mux}); end
      dump_busy = 1'b1;
      repeat (3) @(negedge clock);
      ext_reset = 1'b1;
      opcode = 8'h80; command = 32'h00FF_FFFF; cmd_recv_rx = 1'b1;
      @(negedge clock);
      cmd_recv_rx = 1'b0;
      checks++;
      if (obs_vec() !== '0) begin errors++; $display("FAIL reset_mid_dump: got %h expected 0", obs_vec()); end
      ext_reset = 1'b0; dump_busy = 1'b0; run = 1'b0;
      @(negedge clock);
      checks++;
      if (obs_vec() !== '0 || obs_vec() !== exp_vec())
         begin errors++; $display("FAIL reset_mid_dump_after: got %h expected 0", obs_vec()); end
   endtask

   initial begin
      ext_reset = 1'b1; cmd_recv_rx = 1'b0; opcode = '0; command = '0;
      run = 1'b0; sample_en = 1'b0; meta_busy = 1'b0; dump_busy = 1'b0;
      test_reset();
      test_configure();
      test_id_query();
      test_capture();
      test_random_capture();
      test_abort();
      test_reset_mid_dump();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/capture_controller.md
# capture_controller

Parametrised successor to the first-generation logic-analyzer controller. Decodes the full SUMP-style command set from the command decoder, holds all capture configuration registers, and sequences the complete acquisition cycle (idle, metadata reply, armed, post-trigger capture, data dump). Sits between the UART command decoder and the trigger, sampler, sample memory and metadata units; it is the only block that drives `data_meta_mux`.

## Interface
- `SAMPLE_WIDTH`, 8: probe channels; legal range 1..32.
- `DIV_WIDTH`, 24: sample-clock divider width; legal range 1..24.
- `COUNT_WIDTH`, 16: read/delay counter width; legal range 1..16.

- `clock`  in  1: single clock for all logic.
- `ext_reset`  in  1: synchronous, active-high reset.
- `opcode`  in  8: opcode from the command decoder; valid while `cmd_recv_rx` is high.
- `command`  in  32: command argument, little-endian bytes; valid while `cmd_recv_rx` is high.
- `cmd_recv_rx`  in  1: one-cycle pulse when a complete command is received.
- `run`  in  1: trigger fired (level, held until `arm` drops).
- `sample_en`  in  1: one-cycle pulse per captured sample.
- `meta_busy`  in  1: metadata unit transmitting.
- `dump_busy`  in  1: sample memory streaming to the UART.
- `reset`  out  1: one-cycle soft-reset pulse to the datapath.
- `divider`  out  DIV_WIDTH: sample-clock divider.
- `read_count`, `delay_count`  out  COUNT_WIDTH each: samples read back / samples captured after trigger.
- `rise_pattern`, `fall_pattern`  out  SAMPLE_WIDTH each: edge-trigger masks.
- `arm`  out  1: trigger armed.
- `data_meta_mux`  out  1: 0 routes metadata to the UART, 1 routes sample data.
- `send_id`  out  1: with `begin_meta_transmit`, selects ID reply instead of metadata.
- `begin_meta_transmit`, `begin_dump`  out  1 each: one-cycle start pulses.
- `capture_active`  out  1: high in ARMED, CAPTURE and DUMP.

## Operation
- States: IDLE, META_WAIT, ARMED, CAPTURE, DUMP.
- IDLE, on `cmd_recv_rx`:
  - 0x00: `reset` pulse; stay IDLE.
  - 0x01: `arm`=1; go to ARMED.
  - 0x02: `begin_meta_transmit`+`send_id` pulse, `data_meta_mux`=0; go to META_WAIT.
  - 0x04: same as 0x02 with `send_id`=0.
  - 0x80: `divider`←`command[DIV_WIDTH-1:0]`.
  - 0x81: `read_count`←`command[COUNT_WIDTH-1:0]`, `delay_count`←`command[16+COUNT_WIDTH-1:16]`.
  - 0xC0: `rise_pattern`←`command[SAMPLE_WIDTH-1:0]`.
  - 0xC1: `fall_pattern`←`command[SAMPLE_WIDTH-1:0]`.
  - Any other opcode: ignored; stay IDLE.
- META_WAIT: return to IDLE on the first cycle `meta_busy`=0. `begin_meta_transmit` in the same cycle counts as busy, so the first possible exit is one cycle after it.
- ARMED: on `run`=1, load the down-counter with `delay_count`; go to CAPTURE.
- CAPTURE: decrement on each `sample_en`. At zero: `arm`←0, `data_meta_mux`←1, `begin_dump` pulse, go to DUMP. `delay_count`=0 dumps on the first `sample_en` after `run`.
- DUMP: return to IDLE with `data_meta_mux`←0 on the first cycle `dump_busy`=0 after the `begin_dump` cycle.
- Soft reset (0x00) clears the state and control outputs only; configuration registers are retained.

## Timing
- All outputs are registered. Response appears in the cycle after the `cmd_recv_rx` or `run` edge sampled.
- Pulses (`reset`, `begin_meta_transmit`, `send_id`, `begin_dump`) are exactly one cycle wide.
- `ext_reset` sets every output to 0 and the state to IDLE on the next edge. It overrides a simultaneous `cmd_recv_rx` and is legal mid-capture or mid-dump.
- `run` and `sample_en` in the same ARMED cycle: load only; that sample is not counted.
- Commands arriving outside IDLE are dropped, except as given under Configuration.

## Configuration
- `CAPTURE_ABORT_EN`.
  - Defined: opcode 0x00 is honoured in ARMED, CAPTURE and DUMP. It pulses `reset`, clears `arm` and `data_meta_mux`, and returns to IDLE in one cycle.
  - Undefined: 0x00 outside IDLE is dropped like any other command.

## Structure
- Package `capture_pkg`: opcode localparams (`OP_RESET`, `OP_ARM`, `OP_ID`, `OP_META`, `OP_DIVIDER`, `OP_COUNTS`, `OP_RISE`, `OP_FALL`) and the state enum typedef.
- One sub-module, `post_trigger_counter`: load, decrement on enable, and zero flag, with COUNT_WIDTH.

## Test plan
- Configure: opcode 0x80/command 0x00001234, then 0x81/command 0x0003_0010 → `divider`=0x001234, `delay_count`=3, `read_count`=0x10.
- ID query: opcode 0x02; `meta_busy` high for 20 cycles → one-cycle `begin_meta_transmit`+`send_id`, `data_meta_mux`=0, IDLE one cycle after `meta_busy` falls.
- Capture: opcode 0x01, `run` after 5 cycles, `delay_count`=3 → `begin_dump` one cycle after the 3rd `sample_en`; `arm` falls and `data_meta_mux` rises in that same cycle.
- Dump completion: `dump_busy` high for 10 cycles then low → `data_meta_mux`=0, state IDLE, `capture_active`=0.
- Command dropping: opcode 0xC0 while ARMED → `rise_pattern` unchanged. With `CAPTURE_ABORT_EN` defined, 0x00 in CAPTURE → `reset` pulse, `arm`=0, IDLE.
- Reset mid-dump: `ext_reset` while in DUMP → all outputs 0 on the next edge, including `divider` and the patterns.
